// File: rtl/board_fb_arbiter_pkg.sv
// Shared definitions for the Tetris board framebuffer arbiter.
// Board geometry constants are also used by vga_sync.
package board_fb_arbiter_pkg;

   localparam int ADDR_W_DEF     = 9;
   localparam int BOARD_CELLS    = 2 ** ADDR_W_DEF;
   localparam int FIFO_DEPTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_EMPTY = 2'd1,
      ST_CLEAR      = 2'd2
   } arb_state_t;

endpackage

// File: rtl/board_fb_arbiter_wr_fifo.sv
// Posted-write FIFO for game writes to the board bitmap.
// Pointers carry one extra wrap bit to tell full from empty.
module board_wr_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 8
) (
   input  logic         clk_25mhz,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
   localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

   logic [PW:0]  wr_ptr;
   logic [PW:0]  rd_ptr;
   logic [PW:0]  count;
   logic [W-1:0] mem [DEPTH];

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == CNT_MAX);
   assign empty = (wr_ptr == rd_ptr);
   assign head  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk_25mhz) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk_25mhz) begin
      if (push && !full)
         mem[wr_ptr[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/board_fb_arbiter.sv
// Shares the single-port board RAM between VGA scan-out, posted game
// writes (drained in blanking) and a whole-board clear sequencer.
module board_fb_arbiter
   import board_fb_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              clk_25mhz,
   input  logic              reset,
   input  logic [ADDR_W-1:0] vga_addr,
   input  logic              vga_active,
   output logic              vga_bit,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_data,
   output logic              wr_ready,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic              ram_wdata,
   input  logic              ram_rdata
);

   localparam logic [ADDR_W-1:0] CNT_LAST = '1;
   localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

   arb_state_t        state;
   logic [ADDR_W-1:0] clr_cnt;
   logic              act_d;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [ADDR_W:0]   fifo_head;

   assign wr_ready  = !fifo_full && !clr_busy;
   assign fifo_push = wr_valid && wr_ready;

   board_wr_fifo #(
      .W     (ADDR_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_25mhz (clk_25mhz),
      .reset     (reset),
      .push      (fifo_push),
      .push_data ({wr_addr, wr_data}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // VGA owns the port in the active region; clear beats posted writes.
   always_comb begin
      ram_addr  = vga_addr;
      ram_we    = 1'b0;
      ram_wdata = 1'b0;
      fifo_pop  = 1'b0;
      if (!reset || vga_active) begin
         ram_we = 1'b0;
      end else if (state == ST_CLEAR) begin
         ram_addr = clr_cnt;
         ram_we   = 1'b1;
      end else if (!fifo_empty) begin
         ram_addr  = fifo_head[ADDR_W:1];
         ram_wdata = fifo_head[0];
         ram_we    = 1'b1;
         fifo_pop  = 1'b1;
      end
   end

   always_ff @(posedge clk_25mhz) begin
      if (!reset) begin
         state    <= ST_IDLE;
         clr_cnt  <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
         act_d    <= 1'b0;
         vga_bit  <= 1'b0;
      end else begin
         act_d    <= vga_active;
         vga_bit  <= act_d ? ram_rdata : 1'b0;
         clr_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (clr_start) begin
                  state    <= ST_WAIT_EMPTY;
                  clr_busy <= 1'b1;
               end
            end
            ST_WAIT_EMPTY: begin
               if (fifo_empty)
                  state <= ST_CLEAR;
            end
            ST_CLEAR: begin
               if (!vga_active) begin
                  clr_cnt <= clr_cnt + CNT_ONE;
                  if (clr_cnt == CNT_LAST) begin
                     state    <= ST_IDLE;
                     clr_busy <= 1'b0;
                     clr_done <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_board_fb_arbiter.sv
// Bench for board_fb_arbiter: RAM model plus an in-order write scoreboard.
// Every RAM write must match the queued game write or clear cell.
module tb_board_fb_arbiter;

   typedef struct {
      logic [8:0] a;
      logic       d;
   } wr_t;

   logic       clk_25mhz = 1'b0;
   logic       reset;
   logic [8:0] vga_addr;
   logic       vga_active;
   logic       vga_bit;
   logic       wr_valid;
   logic [8:0] wr_addr;
   logic       wr_data;
   logic       wr_ready;
   logic       clr_start;
   logic       clr_busy;
   logic       clr_done;
   logic [8:0] ram_addr;
   logic       ram_we;
   logic       ram_wdata;
   logic       ram_rdata;

   bit  mem   [512];
   bit  model [512];
   wr_t sbq   [$];
   int  n_chk = 0;
   int  n_bad = 0;
   int  done_cnt = 0;

   board_fb_arbiter dut (
      .clk_25mhz  (clk_25mhz),
      .reset      (reset),
      .vga_addr   (vga_addr),
      .vga_active (vga_active),
      .vga_bit    (vga_bit),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .clr_start  (clr_start),
      .clr_busy   (clr_busy),
      .clr_done   (clr_done),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   always @(posedge clk_25mhz) begin
      if (ram_we)
         mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_25mhz);
      #1;
   endtask

   // Monitor: values seen here are what the next rising edge samples.
   always @(negedge clk_25mhz) begin
      wr_t e;
      if (!reset) begin
         sbq.delete();
         if (ram_we)
            chk("we_in_reset", ram_we, 0);
      end else begin
         if (ram_we) begin
            chk("we_active", vga_active, 0);
            if (sbq.size() == 0) begin
               chk("unexp_wr", ram_we, 0);
            end else begin
               e = sbq.pop_front();
               chk("wr_addr", ram_addr, e.a);
               chk("wr_data", ram_wdata, e.d);
               model[e.a] = e.d;
            end
         end
         if (wr_valid && wr_ready)
            sbq.push_back('{a: wr_addr, d: wr_data});
         if (clr_start && !clr_busy)
            for (int i = 0; i < 512; i++)
               sbq.push_back('{a: 9'(i), d: 1'b0});
         if (clr_done) begin
            done_cnt++;
            chk("busy_at_done", clr_busy, 0);
         end
      end
   end

   task automatic read_cell(input int a, output logic v);
      vga_addr   = 9'(a);
      vga_active = 1'b1;
      tick();
      tick();
      v = vga_bit;
      vga_active = 1'b0;
   endtask

   task automatic read_range(input int lo, input int hi);
      vga_active = 1'b1;
      for (int i = lo; i <= hi + 1; i++) begin
         if (i <= hi)
            vga_addr = 9'(i);
         tick();
         if (i > lo)
            chk($sformatf("cell%0d", i - 1), vga_bit, model[i-1]);
      end
      vga_active = 1'b0;
   endtask

   task automatic push_wr(input int a, input logic d);
      wr_addr  = 9'(a);
      wr_data  = d;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
   endtask

   initial begin
      logic v;
      int   d0;
      int   rdy_bad;
      bit   hit;
      reset = 1'b0; vga_addr = '0; vga_active = 1'b0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = 1'b0; clr_start = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();

      // 1: reset mid-traffic discards posted writes
      vga_active = 1'b1;
      push_wr(10, 1'b1);
      push_wr(11, 1'b1);
      wr_valid = 1'b1; wr_addr = 9'd12; wr_data = 1'b1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vga_active = i[0];
         chk("rst_we", ram_we, 0);
         tick();
         chk("rst_vga_bit", vga_bit, 0);
      end
      wr_valid = 1'b0; vga_active = 1'b0;
      reset = 1'b1;
      tick();
      chk("rel_wr_ready", wr_ready, 1);
      chk("rel_busy", clr_busy, 0);
      chk("rel_done", clr_done, 0);
      chk("rel_vga_bit", vga_bit, 0);
      repeat (3) tick();
      read_range(10, 12);

      // 2: posted writes held during active, drained in order
      vga_active = 1'b1;
      push_wr(5, 1'b1);
      chk("no_we_act0", ram_we, 0);
      push_wr(9, 1'b0);
      push_wr(5, 1'b0);
      tick();
      chk("no_we_act1", ram_we, 0);
      vga_active = 1'b0;
      repeat (4) tick();
      chk("t2_drained", sbq.size(), 0);
      read_cell(5, v);
      chk("cell5_last", v, 0);

      // 3: full FIFO back-pressure
      vga_active = 1'b1;
      for (int i = 0; i < 8; i++)
         push_wr(100 + i, i[0]);
      chk("full_ready", wr_ready, 0);
      wr_addr = 9'd108; wr_data = 1'b1; wr_valid = 1'b1;
      tick();
      chk("held_ready", wr_ready, 0);
      vga_active = 1'b0;
      chk("pop_cyc_ready", wr_ready, 0);
      tick();
      chk("after_pop_ready", wr_ready, 1);
      tick();
      wr_valid = 1'b0;
      repeat (12) tick();
      chk("t3_drained", sbq.size(), 0);
      read_range(100, 108);

      // 4: read latency
      push_wr(37, 1'b1);
      repeat (3) tick();
      vga_addr = 9'd37; vga_active = 1'b1;
      tick();
      chk("lat_n1", vga_bit, 0);
      tick();
      chk("lat_n2", vga_bit, 1);
      vga_active = 1'b0;
      tick();
      chk("blank_n1", vga_bit, 1);
      tick();
      chk("blank_n2", vga_bit, 0);

      // 5: clear after pending writes, interleaved with display
      d0 = done_cnt;
      vga_active = 1'b1;
      push_wr(200, 1'b1);
      push_wr(300, 1'b1);
      push_wr(511, 1'b1);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      chk("busy_set", clr_busy, 1);
      chk("busy_ready", wr_ready, 0);
      rdy_bad = 0;
      for (int c = 0; c < 6000 && done_cnt == d0; c++) begin
         vga_active = ($urandom_range(0, 2) == 0);
         tick();
         if (clr_busy && wr_ready)
            rdy_bad++;
      end
      vga_active = 1'b0;
      repeat (3) tick();
      chk("rdy_while_busy", rdy_bad, 0);
      chk("t5_done_cnt", done_cnt, d0 + 1);
      chk("t5_drained", sbq.size(), 0);
      chk("t5_idle_ready", wr_ready, 1);
      read_range(0, 511);

      // 6: restart ignored, reset aborts walk
      for (int i = 200; i <= 210; i++)
         push_wr(i, 1'b1);
      push_wr(400, 1'b1);
      repeat (3) tick();
      d0 = done_cnt;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      repeat (3) tick();
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 2000 && !hit; c++) begin
         if (ram_we && ram_addr == 9'd200)
            hit = 1'b1;
         else
            tick();
      end
      chk("hit_cell200", hit, 1);
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk("t6_busy", clr_busy, 0);
      chk("t6_ready", wr_ready, 1);
      repeat (5) tick();
      chk("t6_no_done", done_cnt, d0);
      read_range(195, 212);
      read_cell(400, v);
      chk("cell400_kept", v, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
